alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage of the small 8-bit CPU: combinational opcode decoder, PC wait-condition logic, one decode pipeline register stage, and an accumulating ALU with a registered result.
- Sits between program ROM / register file and the register-file write port.
- `result` also drives the CPU output port.

Parameters:
- BUS_WIDTH, 8, datapath width of operands and result.
- OPCODE_WIDTH, 3, opcode width.
- REG_ADDR_WIDTH, 2, register-file write address width.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  reset, asynchronous, active-low.
- opcode  in  OPCODE_WIDTH  instruction opcode field.
- imm  in  BUS_WIDTH  immediate field.
- wr_addr_in  in  REG_ADDR_WIDTH  destination register of current instruction.
- cond_sel  in  1  wait-condition select: 1 = pattern_match, 0 = ready_in.
- cond_inv  in  1  wait polarity (XORed with selected condition).
- ready_in  in  1  external ready level.
- pattern_match  in  1  ready rising-edge pulse.
- sw  in  BUS_WIDTH  synchronised switch input.
- data_a  in  BUS_WIDTH  register-file read port A.
- data_b  in  BUS_WIDTH  register-file read port B.
- pc_en  out  1  program-counter enable (combinational).
- result  out  BUS_WIDTH  registered ALU result.
- wr_en  out  1  register-file write enable, aligned with result.
- wr_addr  out  REG_ADDR_WIDTH  write address, aligned with result.

Behaviour:

Decoder (combinational). Each opcode sets f_wait/f_load/f_add/wr_res and reg_en[4:0]:
- 000 WAIT: f_wait=1; everything else 0.
- 001 LDI: f_load, wr_res; reg_en=00010.
- 010 IN: f_load, wr_res; reg_en=00001.
- 011 MOV: f_load, wr_res; reg_en=00100.
- 100 ADD: f_add, wr_res; reg_en=01100.
- 101 ADDI: f_add, wr_res; reg_en=10100.
- 110 ADDS: f_add, wr_res; reg_en=01001.
- 111 NOP: all 0.

PC wait logic:
- cond = cond_sel ? pattern_match : ready_in (2:1 mux).
- pc_en = ~(f_wait & (cond ^ cond_inv)).
- pc_en is purely combinational from current inputs; it is 1 for every non-WAIT opcode.

Stage 1 registers (capture on the edge after the opcode is presented):
- Captured: imm, f_load, f_add, reg_en, wr_res, wr_addr_in.
- Second-stage copies: wr_res and wr_addr are registered once more so they align with result.

ALU, driven from stage-1 values:
- X = (sw & en[0]) | (imm_r & en[1]) | (data_a & en[2]).
- Y = (data_b & en[3]) | (imm_r & en[4]).
- Sources are AND-OR combined, not priority-muxed.
- On each clock: f_add_r → result <= X+Y mod 2^BUS_WIDTH, carry discarded; else f_load_r → result <= X; else result holds.
- f_add_r takes precedence over f_load_r.

Latency:
- Opcode valid in cycle n → result, wr_en and wr_addr update at the edge ending cycle n+1.
- data_a, data_b and sw are sampled at that same edge, i.e. the values present during cycle n+1.
- Back-to-back instructions are fully pipelined, one per cycle.

Reset (n_reset low, asynchronous):
- All registers clear immediately: result=0, wr_en=0, wr_addr=0, and all stage-1 flags, enables and imm = 0.
- pc_en still follows its combinational equation during reset.
- After release, the first valid result appears 2 edges after the first opcode.

Boundaries:
- 0xFF+0x01 → 0x00.
- A NOP or WAIT in the pipeline holds result and drives wr_en=0.
- WAIT with condition true → pc_en=0; with condition false → pc_en=1.

Test Plan:
- Reset mid-stream: run ADDI, assert n_reset low between edges → result, wr_en and wr_addr go 0 without waiting for a clock edge.
- LDI: imm=0x5A, wr_addr_in=2 → two edges later result=0x5A, wr_en=1, wr_addr=2; following NOP → result holds 0x5A, wr_en=0.
- ADDI wrap-around: data_a=0xF0, imm=0x20 → result=0x10.
- ADD and ADDS:
  - ADD: data_a=0x12, data_b=0x34 → result=0x46.
  - ADDS: sw=0x07, data_b=0x03 → result=0x0A.
  - Sequences are back-to-back and must give results on consecutive cycles.
- WAIT on ready_in:
  - cond_sel=0, cond_inv=0: ready_in=1 → pc_en=0; ready_in=0 → pc_en=1.
  - cond_inv=1 inverts both.
  - Non-WAIT opcode → pc_en=1 regardless of the condition.
- WAIT on pattern: cond_sel=1, cond_inv=1, ready_in held high with pattern_match=0 → pc_en=0; one-cycle pattern_match pulse → pc_en=1 for exactly that cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute stage of the 8-bit CPU: opcode decode, PC wait-condition logic,
// one decode pipeline register and an accumulating ALU with registered result.
module alu_exec_unit #(
    parameter int BUS_WIDTH      = 8,
    parameter int OPCODE_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [BUS_WIDTH-1:0]      imm,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr_in,
    input  logic                      cond_sel,
    input  logic                      cond_inv,
    input  logic                      ready_in,
    input  logic                      pattern_match,
    input  logic [BUS_WIDTH-1:0]      sw,
    input  logic [BUS_WIDTH-1:0]      data_a,
    input  logic [BUS_WIDTH-1:0]      data_b,
    output logic                      pc_en,
    output logic [BUS_WIDTH-1:0]      result,
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] wr_addr
);

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_WAIT = 'd0,
        OP_LDI  = 'd1,
        OP_IN   = 'd2,
        OP_MOV  = 'd3,
        OP_ADD  = 'd4,
        OP_ADDI = 'd5,
        OP_ADDS = 'd6,
        OP_NOP  = 'd7
    } opcode_e;

    opcode_e                   op;
    logic                      f_wait;
    logic                      f_load;
    logic                      f_add;
    logic                      wr_res;
    logic [4:0]                reg_en;
    logic                      cond;

    logic [BUS_WIDTH-1:0]      imm_r;
    logic                      f_load_r;
    logic                      f_add_r;
    logic                      wr_res_r;
    logic [4:0]                en_r;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_r;

    logic [BUS_WIDTH-1:0]      x_op;
    logic [BUS_WIDTH-1:0]      y_op;
    logic [BUS_WIDTH-1:0]      sum;

    assign op = opcode_e'(opcode);

    // reg_en selects ALU sources: [0]=sw [1]=imm->X [2]=data_a [3]=data_b [4]=imm->Y
    always_comb begin
        f_wait = 1'b0;
        f_load = 1'b0;
        f_add  = 1'b0;
        wr_res = 1'b0;
        reg_en = '0;
        case (op)
            OP_WAIT: f_wait = 1'b1;
            OP_LDI:  begin f_load = 1'b1; wr_res = 1'b1; reg_en = 5'b00010; end
            OP_IN:   begin f_load = 1'b1; wr_res = 1'b1; reg_en = 5'b00001; end
            OP_MOV:  begin f_load = 1'b1; wr_res = 1'b1; reg_en = 5'b00100; end
            OP_ADD:  begin f_add  = 1'b1; wr_res = 1'b1; reg_en = 5'b01100; end
            OP_ADDI: begin f_add  = 1'b1; wr_res = 1'b1; reg_en = 5'b10100; end
            OP_ADDS: begin f_add  = 1'b1; wr_res = 1'b1; reg_en = 5'b01001; end
            default: ;
        endcase
    end

    assign cond  = cond_sel ? pattern_match : ready_in;
    assign pc_en = ~(f_wait & (cond ^ cond_inv));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            imm_r     <= '0;
            f_load_r  <= 1'b0;
            f_add_r   <= 1'b0;
            wr_res_r  <= 1'b0;
            en_r      <= '0;
            wr_addr_r <= '0;
        end else begin
            imm_r     <= imm;
            f_load_r  <= f_load;
            f_add_r   <= f_add;
            wr_res_r  <= wr_res;
            en_r      <= reg_en;
            wr_addr_r <= wr_addr_in;
        end
    end

    // Sources are AND-OR merged; the decoder never enables two on one operand
    always_comb begin
        x_op = (sw     & {BUS_WIDTH{en_r[0]}})
             | (imm_r  & {BUS_WIDTH{en_r[1]}})
             | (data_a & {BUS_WIDTH{en_r[2]}});
        y_op = (data_b & {BUS_WIDTH{en_r[3]}})
             | (imm_r  & {BUS_WIDTH{en_r[4]}});
        sum  = x_op + y_op;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            result  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
        end else begin
            if (f_add_r) begin
                result <= sum;
            end else if (f_load_r) begin
                result <= x_op;
            end
            wr_en   <= wr_res_r;
            wr_addr <= wr_addr_r;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed instruction stream with
// hand-computed results, plus reset and PC wait-condition checks.
module tb_alu_exec_unit;

    typedef enum logic [2:0] {
        OP_WAIT = 3'd0, OP_LDI = 3'd1, OP_IN  = 3'd2, OP_MOV = 3'd3,
        OP_ADD  = 3'd4, OP_ADDI = 3'd5, OP_ADDS = 3'd6, OP_NOP = 3'd7
    } op_e;

    typedef struct {
        int         due;
        logic       en;
        logic [7:0] res;
        logic [1:0] addr;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [2:0] opcode = OP_NOP;
    logic [7:0] imm = '0;
    logic [1:0] wr_addr_in = '0;
    logic       cond_sel = 1'b0;
    logic       cond_inv = 1'b0;
    logic       ready_in = 1'b0;
    logic       pattern_match = 1'b0;
    logic [7:0] sw = '0;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic       pc_en;
    logic [7:0] result;
    logic       wr_en;
    logic [1:0] wr_addr;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t sbq[$];
    exp_t mon_e;

    logic [7:0] pend_a = '0;
    logic [7:0] pend_b = '0;
    logic [7:0] pend_sw = '0;
    logic [7:0] last_res = '0;

    alu_exec_unit #(
        .BUS_WIDTH(8),
        .OPCODE_WIDTH(3),
        .REG_ADDR_WIDTH(2)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .opcode(opcode),
        .imm(imm),
        .wr_addr_in(wr_addr_in),
        .cond_sel(cond_sel),
        .cond_inv(cond_inv),
        .ready_in(ready_in),
        .pattern_match(pattern_match),
        .sw(sw),
        .data_a(data_a),
        .data_b(data_b),
        .pc_en(pc_en),
        .result(result),
        .wr_en(wr_en),
        .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issues one instruction; operands for the previous instruction's ALU
    // cycle are driven alongside it, since they are sampled one cycle later.
    task automatic issue(input logic [2:0] op, input logic [7:0] i, input logic [1:0] a,
                         input logic [7:0] da, input logic [7:0] db, input logic [7:0] s,
                         input logic exp_en, input logic [7:0] exp_res);
        exp_t e;
        @(posedge clk);
        #1;
        opcode     = op;
        imm        = i;
        wr_addr_in = a;
        data_a     = pend_a;
        data_b     = pend_b;
        sw         = pend_sw;
        pend_a     = da;
        pend_b     = db;
        pend_sw    = s;
        if (exp_en) last_res = exp_res;
        e.due  = cyc + 2;
        e.en   = exp_en;
        e.res  = last_res;
        e.addr = a;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && n_reset) begin
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                mon_e = sbq.pop_front();
                if (mon_e.due < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL stale: entry due cycle %0d unchecked at cycle %0d", mon_e.due, cyc);
                end else begin
                    check("wr_en", {7'd0, wr_en}, {7'd0, mon_e.en});
                    check("result", result, mon_e.res);
                    check("wr_addr", {6'd0, wr_addr}, {6'd0, mon_e.addr});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 8'h00);
        check("rst_wr_en", {7'd0, wr_en}, 8'h00);
        check("rst_wr_addr", {6'd0, wr_addr}, 8'h00);
        n_reset = 1'b1;
        mon_en  = 1'b1;

        //     op       imm    addr  data_a data_b sw     en    expected
        issue(OP_LDI,  8'h5A, 2'd2, 8'h81, 8'h42, 8'h24, 1'b1, 8'h5A);
        issue(OP_NOP,  8'hEE, 2'd1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00);
        issue(OP_ADDI, 8'h20, 2'd1, 8'hF0, 8'h0F, 8'h0F, 1'b1, 8'h10);
        issue(OP_ADD,  8'hFF, 2'd3, 8'h12, 8'h34, 8'h80, 1'b1, 8'h46);
        issue(OP_ADDS, 8'hFF, 2'd0, 8'hC0, 8'h03, 8'h07, 1'b1, 8'h0A);
        issue(OP_IN,   8'h11, 2'd1, 8'hC3, 8'h99, 8'h3C, 1'b1, 8'h3C);
        issue(OP_MOV,  8'h22, 2'd2, 8'h77, 8'h66, 8'h88, 1'b1, 8'h77);
        issue(OP_WAIT, 8'h33, 2'd3, 8'h55, 8'h55, 8'h55, 1'b0, 8'h00);
        issue(OP_ADDI, 8'h01, 2'd2, 8'hFF, 8'h10, 8'h20, 1'b1, 8'h00);
        issue(OP_ADDI, 8'h01, 2'd3, 8'h40, 8'h08, 8'h04, 1'b1, 8'h41);
        issue(OP_NOP,  8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);

        // Last ADDI has just landed; reset between edges must clear at once
        @(posedge clk);
        #2;
        check("pre_rst_result", result, 8'h41);
        check("pre_rst_wr_en", {7'd0, wr_en}, 8'h01);
        check("pre_rst_wr_addr", {6'd0, wr_addr}, 8'h03);
        mon_en = 1'b0;
        sbq.delete();
        n_reset = 1'b0;
        #1;
        check("async_rst_result", result, 8'h00);
        check("async_rst_wr_en", {7'd0, wr_en}, 8'h00);
        check("async_rst_wr_addr", {6'd0, wr_addr}, 8'h00);

        // PC wait logic, exercised while reset is held
        opcode = OP_WAIT; cond_sel = 1'b0; cond_inv = 1'b0;
        ready_in = 1'b1; #1; check("wait_rdy1", {7'd0, pc_en}, 8'h00);
        ready_in = 1'b0; #1; check("wait_rdy0", {7'd0, pc_en}, 8'h01);
        cond_inv = 1'b1;
        ready_in = 1'b0; #1; check("wait_inv_rdy0", {7'd0, pc_en}, 8'h00);
        ready_in = 1'b1; #1; check("wait_inv_rdy1", {7'd0, pc_en}, 8'h01);
        opcode = OP_ADD; cond_inv = 1'b0; ready_in = 1'b1;
        #1; check("nonwait_pc_en", {7'd0, pc_en}, 8'h01);
        opcode = OP_NOP;
        #1; check("nop_pc_en", {7'd0, pc_en}, 8'h01);

        opcode = OP_WAIT; cond_sel = 1'b1; cond_inv = 1'b1;
        ready_in = 1'b1; pattern_match = 1'b0;
        #1; check("pat_idle", {7'd0, pc_en}, 8'h00);
        @(posedge clk); #1;
        pattern_match = 1'b1;
        @(negedge clk);
        check("pat_pulse", {7'd0, pc_en}, 8'h01);
        @(posedge clk); #1;
        pattern_match = 1'b0;
        #1; check("pat_after", {7'd0, pc_en}, 8'h00);

        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
